// File: rtl/btc_wb_sequencer_if.sv
// Wishbone classic bus between the job sequencer (master) and the hashing core
// register block (slave).
interface btc_wb_sequencer_if;
    logic [7:0]  wb_addr;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic        wb_cycle;
    logic        wb_strobe;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_rdata;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_rty;

    modport master (
        output wb_addr, wb_sel, wb_we, wb_wdata, wb_cycle, wb_strobe, wb_cti, wb_bte,
        input  wb_rdata, wb_ack, wb_err, wb_rty
    );

    modport slave (
        input  wb_addr, wb_sel, wb_we, wb_wdata, wb_cycle, wb_strobe, wb_cti, wb_bte,
        output wb_rdata, wb_ack, wb_err, wb_rty
    );
endinterface

// File: rtl/btc_wb_sequencer.sv
// Loads a 12-word mining job over Wishbone, starts the core, polls its status and
// returns the nonce result (or an error on bus abort/timeout) over a ready/valid port.
module btc_wb_sequencer #(
    parameter logic [7:0]  JOB_BASE    = 8'h00,
    parameter logic [7:0]  CTRL_ADDR   = 8'h30,
    parameter logic [31:0] CTRL_WORD   = 32'h0000_0003,
    parameter logic [7:0]  STATUS_ADDR = 8'h34,
    parameter logic [7:0]  NONCE_ADDR  = 8'h38,
    parameter int unsigned POLL_GAP    = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [31:0]          job_data,
    btc_wb_sequencer_if.master   wb,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_nonce,
    output logic                 res_found,
    output logic                 res_err,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_POLL   = 3'd4;
    localparam logic [2:0] S_NONCE  = 3'd5;
    localparam logic [2:0] S_RESULT = 3'd6;

    localparam logic [3:0]  LAST_IDX = 4'd11;
    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
    localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);

    logic [1:0]  rst_sync_r;
    logic        core_rst_n_s;

    logic [2:0]  state_r;
    logic [3:0]  idx_r;
    logic [15:0] gap_cnt_r;
    logic [7:0]  to_cnt_r;

    logic        wb_cycle_r;
    logic        wb_strobe_r;
    logic        wb_we_r;
    logic [7:0]  wb_addr_r;
    logic [31:0] wb_wdata_r;

    logic        job_ready_r;
    logic        res_valid_r;
    logic [31:0] res_nonce_r;
    logic        res_found_r;
    logic        res_err_r;
    logic        busy_r;

    logic        term_s;
    logic        expire_s;
    logic        bus_abort_s;
    logic        bus_ok_s;
    logic        bus_done_s;

    logic        bus_start_s;
    logic [7:0]  start_addr_s;
    logic        start_we_s;
    logic [31:0] start_wdata_s;

    // Reset synchronizer: asserts with arst_n, releases on the second clk edge after it rises.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign core_rst_n_s = rst_sync_r[1];

    // Responder inputs only count while our own cycle is open; err/rty win over ack.
    assign term_s      = wb_cycle_r & (wb.wb_ack | wb.wb_err | wb.wb_rty);
    assign expire_s    = wb_cycle_r & ~term_s & (to_cnt_r == TO_LAST);
    assign bus_abort_s = (wb_cycle_r & (wb.wb_err | wb.wb_rty)) | expire_s;
    assign bus_ok_s    = term_s & ~wb.wb_err & ~wb.wb_rty;
    assign bus_done_s  = term_s | expire_s;

    // Bus cycle request per state; every request is issued from a cycle with wb_cycle low.
    always_comb begin
        bus_start_s   = 1'b0;
        start_addr_s  = CTRL_ADDR;
        start_we_s    = 1'b0;
        start_wdata_s = 32'h0000_0000;
        case (state_r)
            S_LOAD: begin
                if (job_ready_r && job_valid) begin
                    bus_start_s   = 1'b1;
                    start_addr_s  = JOB_BASE + {2'b00, idx_r, 2'b00};
                    start_we_s    = 1'b1;
                    start_wdata_s = job_data;
                end else begin
                    bus_start_s   = 1'b0;
                end
            end
            S_START: begin
                if (!wb_cycle_r) begin
                    bus_start_s   = 1'b1;
                    start_addr_s  = CTRL_ADDR;
                    start_we_s    = 1'b1;
                    start_wdata_s = CTRL_WORD;
                end else begin
                    bus_start_s   = 1'b0;
                end
            end
            S_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    bus_start_s   = 1'b1;
                    start_addr_s  = STATUS_ADDR;
                end else begin
                    bus_start_s   = 1'b0;
                end
            end
            S_NONCE: begin
                if (!wb_cycle_r) begin
                    bus_start_s   = 1'b1;
                    start_addr_s  = NONCE_ADDR;
                end else begin
                    bus_start_s   = 1'b0;
                end
            end
            default: begin
                bus_start_s = 1'b0;
            end
        endcase
    end

    // Wishbone initiator: opens a cycle on request, closes it on termination or timeout.
    always_ff @(posedge clk or negedge core_rst_n_s) begin
        if (!core_rst_n_s) begin
            wb_cycle_r  <= 1'b0;
            wb_strobe_r <= 1'b0;
            wb_we_r     <= 1'b0;
            wb_addr_r   <= 8'h00;
            wb_wdata_r  <= 32'h0000_0000;
            to_cnt_r    <= 8'h00;
        end else if (bus_done_s) begin
            wb_cycle_r  <= 1'b0;
            wb_strobe_r <= 1'b0;
        end else if (wb_cycle_r) begin
            to_cnt_r    <= to_cnt_r + 8'd1;
        end else if (bus_start_s) begin
            wb_cycle_r  <= 1'b1;
            wb_strobe_r <= 1'b1;
            wb_we_r     <= start_we_s;
            wb_addr_r   <= start_addr_s;
            wb_wdata_r  <= start_wdata_s;
            to_cnt_r    <= 8'h00;
        end
    end

    // Job sequencing FSM; any aborted bus cycle short-circuits to an error result.
    always_ff @(posedge clk or negedge core_rst_n_s) begin
        if (!core_rst_n_s) begin
            state_r     <= S_IDLE;
            idx_r       <= 4'd0;
            gap_cnt_r   <= 16'd0;
            job_ready_r <= 1'b0;
            res_valid_r <= 1'b0;
            res_nonce_r <= 32'h0000_0000;
            res_found_r <= 1'b0;
            res_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else if (bus_abort_s) begin
            state_r     <= S_RESULT;
            job_ready_r <= 1'b0;
            res_valid_r <= 1'b1;
            res_nonce_r <= 32'h0000_0000;
            res_found_r <= 1'b0;
            res_err_r   <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (job_valid) begin
                        state_r     <= S_LOAD;
                        idx_r       <= 4'd0;
                        job_ready_r <= 1'b1;
                        busy_r      <= 1'b1;
                        res_nonce_r <= 32'h0000_0000;
                        res_found_r <= 1'b0;
                        res_err_r   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus_start_s) begin
                        job_ready_r <= 1'b0;
                    end else if (bus_ok_s) begin
                        if (idx_r == LAST_IDX) begin
                            state_r     <= S_START;
                        end else begin
                            idx_r       <= idx_r + 4'd1;
                            job_ready_r <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (bus_ok_s) begin
                        state_r   <= S_GAP;
                        gap_cnt_r <= 16'd0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r   <= S_POLL;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 16'd1;
                    end
                end
                S_POLL: begin
                    if (bus_ok_s) begin
                        if (wb.wb_rdata[0]) begin
                            res_found_r <= wb.wb_rdata[1];
                            state_r     <= S_NONCE;
                        end else begin
                            state_r     <= S_GAP;
                            gap_cnt_r   <= 16'd0;
                        end
                    end
                end
                S_NONCE: begin
                    if (bus_ok_s) begin
                        res_nonce_r <= wb.wb_rdata;
                        res_err_r   <= 1'b0;
                        res_valid_r <= 1'b1;
                        state_r     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    job_ready_r <= 1'b0;
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign wb.wb_cycle  = wb_cycle_r;
    assign wb.wb_strobe = wb_strobe_r;
    assign wb.wb_we     = wb_we_r;
    assign wb.wb_addr   = wb_addr_r;
    assign wb.wb_wdata  = wb_wdata_r;
    assign wb.wb_sel    = 4'hF;
    assign wb.wb_cti    = 3'b000;
    assign wb.wb_bte    = 2'b00;

    assign job_ready = job_ready_r;
    assign res_valid = res_valid_r;
    assign res_nonce = res_nonce_r;
    assign res_found = res_found_r;
    assign res_err   = res_err_r;
    assign busy      = busy_r;

endmodule

// File: doc/btc_wb_sequencer.md
BTC_WB_SEQUENCER -- requirements
Module: btc_wb_sequencer

Interface
REQ-001 Parameter JOB_BASE, default 8'h00: byte address of the first job register; the job registers are 12 consecutive words.
REQ-002 Parameter CTRL_ADDR, default 8'h30: control register byte address.
REQ-003 Parameter CTRL_WORD, default 32'h0000_0003: value written to start a job (bit0 enable, bit1 start).
REQ-004 Parameter STATUS_ADDR, default 8'h34: status register byte address; bit0 done, bit1 nonce_found.
REQ-005 Parameter NONCE_ADDR, default 8'h38: nonce result byte address.
REQ-006 Parameter POLL_GAP, default 16: idle cycles between status reads, range 1..65535.
REQ-007 Parameter TIMEOUT, default 255: maximum cycles to wait for a bus termination, range 1..255.
REQ-008 clk  in  1  single clock; every port is synchronous to it.
REQ-009 arst_n  in  1  asynchronous active-low reset.
REQ-010 job_valid  in  1 / job_ready  out  1 / job_data  in  32: job word stream, 12 words per job (pre_hash_0..7, merkle_root_7, btime, bits, nonce_in).
REQ-011 wb_addr  out  8 / wb_sel  out  4 / wb_we  out  1 / wb_wdata  out  32 / wb_cycle  out  1 / wb_strobe  out  1 / wb_cti  out  3 / wb_bte  out  2: Wishbone classic initiator outputs.
REQ-012 wb_rdata  in  32 / wb_ack  in  1 / wb_err  in  1 / wb_rty  in  1: Wishbone responder inputs.
REQ-013 res_valid  out  1 / res_ready  in  1 / res_nonce  out  32 / res_found  out  1 / res_err  out  1: result handshake.
REQ-014 busy  out  1: high in every state except IDLE.

Function
REQ-015 States: IDLE, LOAD, START, GAP, POLL, NONCE, RESULT.
REQ-016 Bus cycle: wb_cycle=wb_strobe=1 with stable addr/we/wdata until the first clock edge with ack, err, or rty high; both strobes drop on the next cycle; at least one idle cycle separates any two bus cycles.
REQ-017 Constant fields: wb_sel=4'hF, wb_cti=3'b000, wb_bte=2'b00.
REQ-018 IDLE->LOAD when job_valid=1; job_ready is high for exactly one cycle per word and only when no bus cycle is active; a handshake latches job_data and starts a write to JOB_BASE+4*idx.
REQ-019 idx is 4 bits and counts 0..11; after ack on word 11, go to START; between words, stall with job_ready=0 until the write terminates.
REQ-020 START: write CTRL_WORD to CTRL_ADDR; on ack go to GAP.
REQ-021 GAP: a 16-bit counter counts POLL_GAP idle cycles, then go to POLL.
REQ-022 POLL: read STATUS_ADDR; on ack, if rdata[0]=1, latch rdata[1] into res_found and go to NONCE; otherwise go back to GAP.
REQ-023 NONCE: read NONCE_ADDR; on ack, latch rdata into res_nonce, set res_err=0, and go to RESULT.
REQ-024 RESULT: res_valid=1 with outputs held stable until res_ready=1; on that edge go to IDLE; res_valid drops on the next cycle.
REQ-025 Abort: err or rty on any bus cycle, or TIMEOUT cycles without termination (an 8-bit counter reset at each cycle start), ends the bus cycle.
REQ-026 After abort: set res_err=1, res_found=0, res_nonce=0, and go to RESULT; any remaining job words are not consumed.
REQ-027 Bus inputs received while no bus cycle is active are ignored.
REQ-028 job_valid received outside IDLE/LOAD, or while a bus cycle is active, is not acknowledged.

Reset
REQ-029 While arst_n=0, all state is asynchronously cleared: state=IDLE, idx=0, all counters=0.
REQ-030 While arst_n=0, all outputs are 0: wb_cycle, wb_strobe, wb_we, wb_addr, wb_wdata, job_ready, res_*, busy.
REQ-031 Reset mid-transaction drops wb_cycle immediately (asynchronously); no result is produced.
REQ-032 Release of arst_n is synchronized internally; the first action occurs no earlier than the second clk edge after deassertion.

Verification
REQ-033 Happy path: 12 words 0x1..0xC with zero-wait ack -> writes to 0x00..0x2C in order, CTRL write 0x3 to 0x30, status reads with 16 idle cycles between them.
REQ-034 Nonce found: status returns 0x0 twice, then 0x3; nonce reads 0xDEADBEEF -> res_valid with res_nonce=0xDEADBEEF, res_found=1, res_err=0.
REQ-035 Backpressure: res_ready held low for 10 cycles -> res_* stable and busy=1; one cycle after res_ready, busy=0 and a new job is accepted.
REQ-036 Error: wb_err on word 5 -> res_err=1, res_nonce=0, and words 6..11 are not taken; the same check applies with wb_rty.
REQ-037 Timeout: no termination for 255 cycles on the CTRL write -> cycle dropped, res_err=1.
REQ-038 Mid-cycle reset: arst_n pulled low during POLL with cyc=1 -> wb_cycle=0 before the next clk edge, outputs 0, and the next job restarts at idx 0.
